// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 encryption core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  // Forward S-box, row-major: entry 0 is the most significant byte.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 run from MSB to LSB.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_iter_cipher_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [7:0]   sub_b [16];
  logic [127:0] shifted;
  logic [127:0] mixed;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sub_b[i] = sbox(state_in[127-8*i -: 8]);
    end
  end

  // Byte index is row + 4*col; row r takes its byte from column c+r.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(r+4*c) -: 8] = sub_b[r + 4*((c+r)%4)];
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
  end

  assign state_out = (last_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128 encryptor: one round per clock using round keys from the
// key-expansion W bus, valid/ready in and out.
module aes_iter_cipher
  import aes_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int KEY_L     = 128,
  parameter int NO_ROUNDS = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [KEY_L-1:0]            cipher_key,
  input  logic [NO_ROUNDS*DATA_W-1:0] W,
  input  logic                        key_valid,
  input  logic                        key_invalidate,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           plain_text,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           cipher_text,
  output logic                        busy,
  output logic                        abort
);

  // state | meaning
  // IDLE  | waiting for plaintext; accepts only while keys_ok
  // ROUND | applying round round_cnt on each edge
  // DONE  | cipher_text presented until out_ready

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  round_cnt;
  logic [DATA_W-1:0] st, round_out, round_key;
  logic              keys_ok, accept, kill, finish, last_round;

  assign last_round = (round_cnt == CNT_W'(NO_ROUNDS));

  always_comb begin
    round_key = '0;
    for (int k = 1; k <= NO_ROUNDS; k++) begin
      if (round_cnt == CNT_W'(k)) round_key = W[(NO_ROUNDS-k)*DATA_W +: DATA_W];
    end
  end

  aes_round u_round (
    .state_in   (st),
    .round_key  (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    kill      = 1'b0;
    finish    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = keys_ok & ~key_invalidate;
        accept   = in_valid & in_ready;
        if (accept) state_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (key_invalidate) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (last_round) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // A key change must not let a stale ciphertext complete its handshake.
        if (key_invalidate) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      keys_ok     <= 1'b0;
      round_cnt   <= '0;
      st          <= '0;
      cipher_text <= '0;
      abort       <= 1'b0;
    end else begin
      abort <= kill;
      if (key_invalidate) keys_ok <= 1'b0;
      else if (key_valid) keys_ok <= 1'b1;

      if (kill) begin
        cipher_text <= '0;
        round_cnt   <= '0;
      end else if (accept) begin
        st        <= plain_text ^ cipher_key;
        round_cnt <= CNT_W'(1);
      end else if (state == ROUND) begin
        st <= round_out;
        if (finish) cipher_text <= round_out;
        else        round_cnt   <= round_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Directed bench for aes_iter_cipher: FIPS-197 vectors, back-pressure, key
// gating and abort, reset, and back-to-back blocks against a software model.
module tb_aes_iter_cipher;

  logic           clk = 1'b0;
  logic           reset;
  logic [127:0]   cipher_key;
  logic [1279:0]  W;
  logic           key_valid, key_invalidate;
  logic           in_valid, in_ready;
  logic [127:0]   plain_text;
  logic           out_valid, out_ready;
  logic [127:0]   cipher_text;
  logic           busy, abort;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_iter_cipher dut (
    .clk            (clk),
    .reset          (reset),
    .cipher_key     (cipher_key),
    .W              (W),
    .key_valid      (key_valid),
    .key_invalidate (key_invalidate),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .plain_text     (plain_text),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .cipher_text    (cipher_text),
    .busy           (busy),
    .abort          (abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // GF(2^8) multiply, used to derive the S-box from first principles.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [1279:0] key_sched(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1279:0] bus;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 1; k <= 10; k++) begin
      bus[1279-128*(k-1) -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    end
    return bus;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [1279:0] ks,
                                           input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int row = 0; row < 4; row++) begin
        for (int col = 0; col < 4; col++) s[row+4*col] = t[row + 4*((col+row)%4)];
      end
      if (r < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      rk = ks[1279-128*(r-1) -: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_key_valid();
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic launch(input logic [127:0] pt);
    plain_text = pt;
    in_valid   = 1'b1;
    check("accept_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1279:0] wb, wc, wr;
    logic [127:0]  rkey, rpt, rexp;
    int            lat, t_acc;
    logic          seen;

    reset = 1'b0; key_valid = 1'b0; key_invalidate = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    cipher_key = '0; plain_text = '0; W = '0;
    build_sbox();
    wb = key_sched(KEY_B);
    wc = key_sched(KEY_C);

    step(); step();
    check("rst_in_ready",  128'(in_ready),  128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_abort",     128'(abort),     128'd0);
    check("rst_ct",        cipher_text,     128'd0);
    reset = 1'b1;

    // No key yet: plaintext must be ignored.
    cipher_key = KEY_B; W = wb;
    plain_text = PT_B; in_valid = 1'b1;
    repeat (3) begin
      check("gate_ready", 128'(in_ready), 128'd0);
      step();
    end
    check("gate_busy", 128'(busy), 128'd0);
    in_valid = 1'b0;

    key_valid = 1'b1; key_invalidate = 1'b1;
    step();
    key_valid = 1'b0; key_invalidate = 1'b0;
    check("inv_wins", 128'(in_ready), 128'd0);
    pulse_key_valid();
    check("keys_ok_ready", 128'(in_ready), 128'd1);

    // App. B
    out_ready = 1'b1;
    launch(PT_B);
    check("b_busy", 128'(busy), 128'd1);
    wait_out(lat);
    check("b_latency", 128'(lat), 128'd10);
    check("b_ct", cipher_text, CT_B);
    step();
    check("b_out_drop", 128'(out_valid), 128'd0);
    check("b_ready_back", 128'(in_ready), 128'd1);

    // App. C with back-pressure
    cipher_key = KEY_C; W = wc; out_ready = 1'b0;
    launch(PT_C);
    wait_out(lat);
    check("c_latency", 128'(lat), 128'd10);
    check("c_ct", cipher_text, CT_C);
    repeat (20) begin
      step();
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_ct_stable", cipher_text, CT_C);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_release_ready", 128'(in_ready), 128'd1);

    // Reset during ROUND
    cipher_key = KEY_B; W = wb;
    launch(PT_B);
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rr_busy",      128'(busy),      128'd0);
    check("rr_out_valid", 128'(out_valid), 128'd0);
    check("rr_in_ready",  128'(in_ready),  128'd0);
    check("rr_abort",     128'(abort),     128'd0);
    check("rr_ct",        cipher_text,     128'd0);
    reset = 1'b1;

    // Reset during DONE
    out_ready = 1'b0;
    pulse_key_valid();
    launch(PT_B);
    wait_out(lat);
    check("rd_ct_before", cipher_text, CT_B);
    reset = 1'b0;
    step();
    check("rd_busy",      128'(busy),      128'd0);
    check("rd_out_valid", 128'(out_valid), 128'd0);
    check("rd_in_ready",  128'(in_ready),  128'd0);
    check("rd_ct",        cipher_text,     128'd0);
    reset = 1'b1;

    pulse_key_valid();
    out_ready = 1'b1;
    launch(PT_B);
    wait_out(lat);
    check("fresh_latency", 128'(lat), 128'd10);
    check("fresh_ct", cipher_text, CT_B);
    step();

    // Invalidate while round 5 is pending
    launch(PT_B);
    repeat (4) step();
    key_invalidate = 1'b1;
    check("ab_ready_low", 128'(in_ready), 128'd0);
    step();
    key_invalidate = 1'b0;
    check("ab_pulse",     128'(abort),     128'd1);
    check("ab_busy",      128'(busy),      128'd0);
    check("ab_out_valid", 128'(out_valid), 128'd0);
    check("ab_ct",        cipher_text,     128'd0);
    step();
    check("ab_one_cycle", 128'(abort), 128'd0);
    in_valid = 1'b1; plain_text = PT_B;
    seen = 1'b0;
    repeat (15) begin
      step();
      if (out_valid || in_ready || busy) seen = 1'b1;
    end
    check("ab_quiet", 128'(seen), 128'd0);
    in_valid = 1'b0;
    pulse_key_valid();
    check("ab_rekey_ready", 128'(in_ready), 128'd1);

    // Invalidate in DONE beats a simultaneous out_ready
    out_ready = 1'b0;
    launch(PT_B);
    wait_out(lat);
    check("dn_ct_before", cipher_text, CT_B);
    out_ready = 1'b1; key_invalidate = 1'b1;
    step();
    key_invalidate = 1'b0;
    check("dn_abort",     128'(abort),     128'd1);
    check("dn_out_valid", 128'(out_valid), 128'd0);
    check("dn_ct",        cipher_text,     128'd0);
    check("dn_in_ready",  128'(in_ready),  128'd0);
    pulse_key_valid();

    // Back-to-back random blocks
    rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
    wr   = key_sched(rkey);
    cipher_key = rkey; W = wr; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rexp = aes_ref(rkey, wr, rpt);
      launch(rpt);
      t_acc = cyc;
      wait_out(lat);
      check("b2b_ct", cipher_text, rexp);
      step();
      check("b2b_cycles", 128'(cyc - t_acc), 128'd11);
      check("b2b_ready", 128'(in_ready), 128'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_iter_cipher.md
Name: aes_iter_cipher

Overview:
- Iterative AES-128 encryption datapath that consumes the round-key bus produced by the pipelined key-expansion stage.
- It applies one full round per clock, 10 rounds per block.
- It takes one plaintext block at a time over a valid/ready handshake and returns the ciphertext over a second valid/ready handshake.
- It sits between the SoC register interface (upstream) and the key-expansion stage, whose W bus and final valid bit it reads.

Parameters:
- DATA_W, 128, block width in bits (only 128 supported).
- KEY_L, 128, key length in bits (only 128 supported).
- NO_ROUNDS, 10, number of rounds; sizes the W bus and the round counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-low reset.
- cipher_key  in  KEY_L  round-0 key, XORed with the plaintext before round 1.
- W  in  NO_ROUNDS*DATA_W  round keys. W[1279:1152] is round 1 and W[127:0] is round 10; each round's key is the next lower 128-bit slice.
- key_valid  in  1  high when W is complete; driven by the key-expansion stage's last valid bit.
- key_invalidate  in  1  one-cycle pulse when upstream starts loading a new key.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  block can accept plaintext.
- plain_text  in  DATA_W  plaintext, byte 0 at [127:120].
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- cipher_text  out  DATA_W  ciphertext, same byte order as plain_text.
- busy  out  1  high in ROUND or DONE.
- abort  out  1  one-cycle pulse when an in-flight block is dropped.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, keys_ok=0, round_cnt=0.
  - state register = 0; cipher_text=0.
  - in_ready=0, out_valid=0, busy=0, abort=0.
- keys_ok flag:
  - Set at any edge where key_valid==1.
  - Cleared at any edge where key_invalidate==1.
  - If both are high in the same cycle, invalidate wins.
- in_ready = (state==IDLE) & keys_ok & ~key_invalidate. It is combinational from registers and key_invalidate.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - Accept occurs on in_valid & in_ready.
  - On accept: st <= plain_text ^ cipher_key, round_cnt <= 1, go to ROUND.
  - in_valid while in_ready==0 is ignored and is not queued.
- ROUND, each edge:
  - st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), W slice[round_cnt]).
  - When round_cnt==NO_ROUNDS, MixColumns is bypassed.
  - round_cnt increments by 1 while below NO_ROUNDS.
  - After the round-10 edge, go to DONE.
  - cipher_text is loaded with the round-10 result on that same edge.
- DONE:
  - out_valid=1; cipher_text is held stable until out_valid & out_ready.
  - Then go to IDLE; out_valid drops at that edge.
  - in_ready stays 0 throughout DONE, so there is no overlap between blocks.
- Latency:
  - Accept at edge T; out_valid is high from edge T+10.
  - Minimum 11 cycles per block with out_ready held high.
- Abort, when key_invalidate==1 in ROUND or DONE:
  - Go to IDLE and drop out_valid.
  - Pulse abort for one cycle.
  - cipher_text is cleared to 0.
  - In DONE, invalidate wins over a simultaneous out_ready; the handshake does not complete.
- Reset mid-operation returns every output to its reset value at that edge.
- key_valid dropping while keys_ok==1 has no effect. Only key_invalidate clears keys_ok.
- GF(2^8) arithmetic:
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
  - MixColumns uses the fixed {02,03,01,01} circulant per column.
  - ShiftRows rotates row r left by r bytes, with column-major byte order as in FIPS-197.

Decomposition:
- Package aes_pkg holds:
  - the state enum {IDLE, ROUND, DONE};
  - the round-counter width localparam (4 bits);
  - the S-box table as a constant function;
  - the xtime and mix_column functions.
- Sub-module aes_round: purely combinational.
  - Inputs: state_in[127:0], round_key[127:0], last_round.
  - Output: state_out[127:0].
  - Contains 16 S-box lookups; instantiated once.
- The FSM, counter, keys_ok, round-key slice mux and handshakes live in aes_iter_cipher.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, W from the golden schedule model, key_valid=1, pt 3243f6a8885a308d313198a2e0370734 -> cipher_text 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure: hold out_ready=0 for 20 cycles -> out_valid stays 1, cipher_text stable, in_ready=0; raise out_ready -> out_valid drops next edge and in_ready returns to 1 the same cycle.
- Key gating: before any key_valid, in_valid=1 -> in_ready=0, no accept; then key_invalidate pulse in round 5 -> abort pulse, state IDLE, out_valid never asserts, in_ready=0 until key_valid seen again.
- Reset: reset=0 during ROUND and during DONE -> all outputs 0 next edge; then a fresh App. B block completes correctly.
- Back-to-back: 3 random blocks with out_ready=1, compared against a reference model -> all match, 11 cycles per block.
